vga_timing_gen: RTL and testbench

- Source end of the vga_if stream: generates horizontal/vertical counters, sync and blanking for the 1024x768@60 Hz mode (65 MHz pixel clock).
- Sits at the head of the drawing pipeline. Every draw_* stage consumes its vga_if.out via vga_if.in.
- Drives rgb to black so downstream stages overlay onto a defined background.
- Also emits a one-cycle frame_start pulse used by game logic for per-frame updates.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_if.sv | 15 +
 rtl/mod_counter.sv | 34 +++
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 1024x768@60 timing constants, counter width and flag helpers
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int HOR_VIS         = 1024;
  localparam int HOR_SYNC_START  = 1048;
  localparam int HOR_SYNC_STOP   = 1184;
  localparam int HOR_TOTAL       = 1344;

  localparam int VER_VIS         = 768;
  localparam int VER_SYNC_START  = 771;
  localparam int VER_SYNC_STOP   = 777;
  localparam int VER_TOTAL       = 806;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
  } vga_flags_t;

  // Half-open window test used for the sync pulses: lo <= x < hi.
  function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel-stream bundle passed between drawing pipeline stages
interface vga_if;
  import vga_pkg::*;

  cnt_t        hcount;
  logic        hsync;
  logic        hblnk;
  cnt_t        vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N counter with enable, look-ahead value and wrap strobe
module mod_counter #(
  parameter int W   = 11,
  parameter int MOD = 1344
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  // Look-ahead value lets the parent register decoded flags alongside the count.
  always_comb begin
    wrap       = en && (count == LAST);
    count_next = count;
    if (en) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
  end

  // Counter state; reset returns to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - head of the drawing pipeline: counters, sync, blanking, black rgb
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HVIS        = HOR_VIS,
  parameter int HSYNC_START = HOR_SYNC_START,
  parameter int HSYNC_STOP  = HOR_SYNC_STOP,
  parameter int HTOTAL      = HOR_TOTAL,
  parameter int VVIS        = VER_VIS,
  parameter int VSYNC_START = VER_SYNC_START,
  parameter int VSYNC_STOP  = VER_SYNC_STOP,
  parameter int VTOTAL      = VER_TOTAL
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   out,
  output logic frame_start
);

  if ((HTOTAL > (1 << CNT_W)) || (VTOTAL > (1 << CNT_W))) begin : g_total_too_big
    $error("vga_timing_gen: HTOTAL/VTOTAL exceed counter range");
  end

  if (!((HVIS < HSYNC_START) && (HSYNC_START < HSYNC_STOP) && (HSYNC_STOP <= HTOTAL))) begin : g_bad_hor
    $error("vga_timing_gen: horizontal timing parameters out of order");
  end

  if (!((VVIS < VSYNC_START) && (VSYNC_START < VSYNC_STOP) && (VSYNC_STOP <= VTOTAL))) begin : g_bad_ver
    $error("vga_timing_gen: vertical timing parameters out of order");
  end

  localparam cnt_t HVIS_C   = CNT_W'(HVIS);
  localparam cnt_t HSS_C    = CNT_W'(HSYNC_START);
  localparam cnt_t HSE_C    = CNT_W'(HSYNC_STOP);
  localparam cnt_t VVIS_C   = CNT_W'(VVIS);
  localparam cnt_t VSS_C    = CNT_W'(VSYNC_START);
  localparam cnt_t VSE_C    = CNT_W'(VSYNC_STOP);

  cnt_t       hcnt;
  cnt_t       hcnt_next;
  cnt_t       vcnt;
  cnt_t       vcnt_next;
  logic       h_wrap;
  logic       v_wrap;
  vga_flags_t flags_next;

  mod_counter #(.W(CNT_W), .MOD(HTOTAL)) u_hcnt (
    .clk        (clk),
    .rst        (rst),
    .en         (1'b1),
    .count      (hcnt),
    .count_next (hcnt_next),
    .wrap       (h_wrap)
  );

  mod_counter #(.W(CNT_W), .MOD(VTOTAL)) u_vcnt (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count      (vcnt),
    .count_next (vcnt_next),
    .wrap       (v_wrap)
  );

  // Decode from the look-ahead counts so each registered flag matches the count it lands with.
  always_comb begin
    flags_next       = '0;
    flags_next.hblnk = (hcnt_next >= HVIS_C);
    flags_next.hsync = in_window(hcnt_next, HSS_C, HSE_C);
    flags_next.vblnk = (vcnt_next >= VVIS_C);
    flags_next.vsync = in_window(vcnt_next, VSS_C, VSE_C);
  end

  // Output registers; frame_start fires when both counters roll over together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hsync   <= 1'b0;
      out.hblnk   <= 1'b0;
      out.vsync   <= 1'b0;
      out.vblnk   <= 1'b0;
      out.rgb     <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      out.hsync   <= flags_next.hsync;
      out.hblnk   <= flags_next.hblnk;
      out.vsync   <= flags_next.vsync;
      out.vblnk   <= flags_next.vblnk;
      out.rgb     <= 12'h000;
      frame_start <= h_wrap && v_wrap;
    end
  end

  assign out.hcount = hcnt;
  assign out.vcount = vcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  logic fs_full;
  logic fs_small;

  vga_if vga_full ();
  vga_if vga_small ();

  vga_timing_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .out         (vga_full),
    .frame_start (fs_full)
  );

  vga_timing_gen #(
    .HVIS(16), .HSYNC_START(18), .HSYNC_STOP(22), .HTOTAL(26),
    .VVIS(8),  .VSYNC_START(9),  .VSYNC_STOP(11), .VTOTAL(13)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .out         (vga_small),
    .frame_start (fs_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [38:0] exp_vec(input int h, input int v, input bit fs,
                                          input int hvis, input int hss, input int hse,
                                          input int vvis, input int vss, input int vse);
    logic [10:0] hh;
    logic [10:0] vv;
    logic hs, hb, vs, vb;
    hh = h[10:0];
    vv = v[10:0];
    hs = (h >= hss) && (h < hse);
    hb = (h >= hvis);
    vs = (v >= vss) && (v < vse);
    vb = (v >= vvis);
    return {hh, vv, hs, hb, vs, vb, 12'h000, fs};
  endfunction

  task automatic adv(inout int h, inout int v, inout bit fs, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
    fs = (h == 0) && (v == 0);
  endtask

  int mh, mv, sh, sv;
  bit mfs, sfs;
  int cyc, fs_last, fs_count, vs_cnt, hs_cnt;
  bit hs_done, wrap_done, prev_vb;

  function automatic logic [38:0] full_act();
    return {vga_full.hcount, vga_full.vcount, vga_full.hsync, vga_full.hblnk,
            vga_full.vsync, vga_full.vblnk, vga_full.rgb, fs_full};
  endfunction

  function automatic logic [38:0] small_act();
    return {vga_small.hcount, vga_small.vcount, vga_small.hsync, vga_small.hblnk,
            vga_small.vsync, vga_small.vblnk, vga_small.rgb, fs_small};
  endfunction

  task automatic reset_model();
    mh = 0; mv = 0; mfs = 0;
    sh = 0; sv = 0; sfs = 0;
    cyc = 0; fs_last = -1; vs_cnt = 0; prev_vb = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    adv(mh, mv, mfs, 1344, 806);
    adv(sh, sv, sfs, 26, 13);
    check("full_vec", full_act(), exp_vec(mh, mv, mfs, 1024, 1048, 1184, 768, 771, 777));
    check("small_vec", small_act(), exp_vec(sh, sv, sfs, 16, 18, 22, 8, 9, 11));

    if (mh == 1023) check("hblnk_at_1023", vga_full.hblnk, 0);
    if (mh == 1024) check("hblnk_at_1024", vga_full.hblnk, 1);
    if (mh == 1047) check("hsync_at_1047", vga_full.hsync, 0);
    if (mh == 1048) check("hsync_at_1048", vga_full.hsync, 1);
    if (mh == 1183) check("hsync_at_1183", vga_full.hsync, 1);
    if (mh == 1184) check("hsync_at_1184", vga_full.hsync, 0);
    if (mv == 0 && vga_full.hsync) hs_cnt++;
    if (!hs_done && mv == 1 && mh == 0) begin
      hs_done = 1;
      check("hsync_len", hs_cnt, 136);
    end
    if (!wrap_done && mv == 1 && mh == 0) begin
      wrap_done = 1;
      check("hwrap_hcount", vga_full.hcount, 0);
      check("hwrap_vcount", vga_full.vcount, 1);
    end

    if (fs_small) begin
      if (fs_last < 0) check("fs_first", cyc, 338);
      else check("fs_period", cyc - fs_last, 338);
      fs_last = cyc;
      fs_count++;
    end
    if (sfs) begin
      check("vsync_lines", vs_cnt, 52);
      vs_cnt = 0;
    end
    if (vga_small.vsync) vs_cnt++;
    if (vga_small.vblnk && !prev_vb) begin
      check("vblnk_rise_v", vga_small.vcount, 8);
      check("vblnk_rise_h", vga_small.hcount, 0);
    end
    prev_vb = vga_small.vblnk;
  endtask

  initial begin
    bit reached;
    rst = 1'b1;
    hs_cnt = 0; hs_done = 0; wrap_done = 0; fs_count = 0;
    reset_model();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_full", full_act(), 39'h0);
    check("rst_small", small_act(), 39'h0);
    rst = 1'b0;

    for (int i = 0; i < 4100; i++) step();
    check("fs_count", fs_count, 12);

    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      if (sh == 10 && sv == 5) reached = 1;
      else step();
    end
    check("reach_mid_frame", reached, 1);

    rst = 1'b1;
    @(negedge clk);
    check("midrst_full", full_act(), 39'h0);
    check("midrst_small", small_act(), 39'h0);
    check("midrst_fs", fs_small, 0);
    reset_model();
    rst = 1'b0;
    @(negedge clk);
    cyc++;
    adv(mh, mv, mfs, 1344, 806);
    adv(sh, sv, sfs, 26, 13);
    check("restart_h", vga_full.hcount, 1);
    check("restart_v", vga_full.vcount, 0);
    check("restart_fs", fs_small, 0);
    for (int i = 0; i < 700; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
